// File: rtl/rle_stream_compressor.sv
// Streaming run-length compressor: pixels in, (count, pixel-bytes) tokens out over a byte handshake.
// Runs close at row ends; a per-row raw mode bypasses RLE and emits pixel bytes only.
module rle_stream_compressor #(
  parameter int ROW_PIXELS = 640,
  parameter int PIXEL_W    = 16,
  parameter int MAX_RUN    = 255,
  parameter bit EOR_MARK   = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PIXEL_W-1:0] i_pixel,
  input  logic               i_valid,
  output logic               o_in_ready,
  input  logic               i_mode,
  output logic [7:0]         o_byte,
  output logic               o_valid,
  input  logic               i_out_ready,
  output logic               o_row_done
);

  localparam int PB    = PIXEL_W / 8;
  localparam int COL_W = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CNT, S_PIX, S_EOR} state_t;

  state_t             state;
  logic [COL_W-1:0]   col;
  logic               row_mode;
  logic               run_open;
  logic [PIXEL_W-1:0] run_val;
  logic [7:0]         run_cnt;
  logic [PIXEL_W-1:0] shreg;
  logic [1:0]         idx;
  logic               flush_pending;
  logic [PIXEL_W-1:0] flush_val;
  logic               eor_pending;
  logic               row_end;

  logic accept, xfer, last_col, mode, extend, close_old, final_byte;

  assign accept     = i_valid & o_in_ready;
  assign xfer       = o_valid & i_out_ready;
  assign last_col   = (col == COL_W'(ROW_PIXELS - 1));
  // Mode is latched with the column-0 pixel and held for the rest of the row.
  assign mode       = (col == '0) ? i_mode : row_mode;
  assign extend     = run_open && (i_pixel == run_val) && (run_cnt < 8'(MAX_RUN));
  assign close_old  = run_open && !extend;
  assign final_byte = (state == S_EOR) ||
                      ((state == S_PIX) && (idx == 2'(PB - 1)) && !flush_pending && !eor_pending);
  assign o_row_done = xfer & row_end & final_byte;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= S_IDLE;
      col           <= '0;
      row_mode      <= 1'b0;
      run_open      <= 1'b0;
      run_val       <= '0;
      run_cnt       <= 8'd0;
      shreg         <= '0;
      idx           <= 2'd0;
      flush_pending <= 1'b0;
      flush_val     <= '0;
      eor_pending   <= 1'b0;
      row_end       <= 1'b0;
      o_byte        <= 8'd0;
      o_valid       <= 1'b0;
      o_in_ready    <= 1'b1;
    end else if (accept) begin
      col <= last_col ? '0 : col + COL_W'(1);
      if (col == '0) row_mode <= i_mode;
      if (mode) begin
        o_byte        <= i_pixel[PIXEL_W-1 -: 8];
        shreg         <= i_pixel << 8;
        idx           <= 2'd0;
        state         <= S_PIX;
        o_valid       <= 1'b1;
        o_in_ready    <= 1'b0;
        row_end       <= last_col;
        eor_pending   <= 1'b0;
        flush_pending <= 1'b0;
        run_open      <= 1'b0;
      end else if (last_col) begin
        // Row flush: close everything; a mismatching last pixel becomes a queued 1-pixel run.
        o_valid     <= 1'b1;
        o_in_ready  <= 1'b0;
        state       <= S_CNT;
        row_end     <= 1'b1;
        eor_pending <= EOR_MARK;
        run_open    <= 1'b0;
        if (close_old) begin
          o_byte        <= run_cnt;
          shreg         <= run_val;
          flush_pending <= 1'b1;
          flush_val     <= i_pixel;
        end else if (extend) begin
          o_byte        <= run_cnt + 8'd1;
          shreg         <= run_val;
          flush_pending <= 1'b0;
        end else begin
          o_byte        <= 8'd1;
          shreg         <= i_pixel;
          flush_pending <= 1'b0;
        end
      end else begin
        run_open <= 1'b1;
        if (extend) begin
          run_cnt <= run_cnt + 8'd1;
        end else begin
          run_val <= i_pixel;
          run_cnt <= 8'd1;
        end
        if (close_old) begin
          o_byte        <= run_cnt;
          shreg         <= run_val;
          o_valid       <= 1'b1;
          o_in_ready    <= 1'b0;
          state         <= S_CNT;
          row_end       <= 1'b0;
          eor_pending   <= 1'b0;
          flush_pending <= 1'b0;
        end
      end
    end else if (xfer) begin
      case (state)
        S_CNT: begin
          o_byte <= shreg[PIXEL_W-1 -: 8];
          shreg  <= shreg << 8;
          idx    <= 2'd0;
          state  <= S_PIX;
        end
        S_PIX: begin
          if (idx != 2'(PB - 1)) begin
            o_byte <= shreg[PIXEL_W-1 -: 8];
            shreg  <= shreg << 8;
            idx    <= idx + 2'd1;
          end else if (flush_pending) begin
            o_byte        <= 8'd1;
            shreg         <= flush_val;
            flush_pending <= 1'b0;
            state         <= S_CNT;
          end else if (eor_pending) begin
            o_byte      <= 8'd0;
            eor_pending <= 1'b0;
            state       <= S_EOR;
          end else begin
            state      <= S_IDLE;
            o_valid    <= 1'b0;
            o_in_ready <= 1'b1;
          end
        end
        S_EOR: begin
          state      <= S_IDLE;
          o_valid    <= 1'b0;
          o_in_ready <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          o_valid    <= 1'b0;
          o_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rle_stream_compressor.sv
// Directed bench for rle_stream_compressor with ROW_PIXELS=8, MAX_RUN=4, PIXEL_W=16, EOR_MARK=1.
module tb_rle_stream_compressor;

  logic        clk;
  logic        RST;
  logic [15:0] i_pixel;
  logic        i_valid;
  logic        o_in_ready;
  logic        i_mode;
  logic [7:0]  o_byte;
  logic        o_valid;
  logic        out_ready;
  logic        o_row_done;

  int tests  = 0;
  int errors = 0;

  logic [7:0] q[$];
  int         done_cnt = 0;
  int         done_idx = 0;
  int         stall_viol = 0;
  int         ready_viol = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_byte = 8'd0;
  bit         rand_mode = 0;

  rle_stream_compressor #(
    .ROW_PIXELS(8), .PIXEL_W(16), .MAX_RUN(4), .EOR_MARK(1'b1)
  ) dut (
    .CLK(clk), .RST(RST), .i_pixel(i_pixel), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .i_mode(i_mode), .o_byte(o_byte), .o_valid(o_valid), .i_out_ready(out_ready),
    .o_row_done(o_row_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) == 0);
    else           out_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (!RST) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!o_valid || o_byte !== prev_byte)) stall_viol++;
      if (o_valid && o_in_ready && !out_ready) ready_viol++;
      if (o_valid && out_ready) q.push_back(o_byte);
      if (o_row_done) begin
        done_cnt++;
        done_idx = q.size();
      end
      prev_stall = o_valid && !out_ready;
      prev_byte  = o_byte;
    end
  end

  task automatic send_pixel(input logic [15:0] p, input logic m);
    int n = 0;
    while (!o_in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      errors++;
      $display("FAIL in_ready_timeout got 0 want 1 (pixel %h)", p);
    end
    i_pixel = p;
    i_mode  = m;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    tests++;
    if (k >= 3000) begin
      errors++;
      $display("FAIL drain_timeout got %0d bytes want %0d", q.size(), n);
    end
  endtask

  task automatic clear_mon();
    q.delete();
    done_cnt   = 0;
    done_idx   = 0;
    stall_viol = 0;
    ready_viol = 0;
  endtask

  task automatic test_reset();
    RST = 1'b0; i_valid = 1'b0; i_pixel = 16'h0; i_mode = 1'b0;
    #12;
    tests++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    tests++; if (o_byte !== 8'h00) begin errors++; $display("FAIL reset_o_byte got %h want 00", o_byte); end
    tests++; if (o_row_done !== 1'b0) begin errors++; $display("FAIL reset_row_done got %b want 0", o_row_done); end
    tests++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", o_in_ready); end
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_uniform_row(input string nm);
    logic [7:0] exp[$];
    bit bad;
    exp = '{8'h04, 8'hAB, 8'hCD, 8'h04, 8'hAB, 8'hCD, 8'h00};
    clear_mon();
    for (int i = 0; i < 8; i++) send_pixel(16'hABCD, 1'b0);
    drain(exp.size());
    tests++;
    if (q.size() != exp.size()) begin errors++; $display("FAIL %s_len got %0d want %0d", nm, q.size(), exp.size()); end
    tests++; bad = 0;
    foreach (exp[i]) if (i < q.size() && q[i] !== exp[i] && !bad) begin
      bad = 1; $display("FAIL %s_byte[%0d] got %h want %h", nm, i, q[i], exp[i]);
    end
    if (bad) errors++;
    tests++; if (done_cnt != 1) begin errors++; $display("FAIL %s_row_done got %0d want 1", nm, done_cnt); end
    tests++; if (stall_viol != 0) begin errors++; $display("FAIL %s_stall_stable got %0d want 0", nm, stall_viol); end
  endtask

  task automatic test_alternating();
    logic [7:0] exp[$];
    bit bad;
    for (int i = 0; i < 8; i++) begin
      exp.push_back(8'h01);
      exp.push_back((i % 2 == 0) ? 8'hAA : 8'hBB);
      exp.push_back((i % 2 == 0) ? 8'hAA : 8'hBB);
    end
    exp.push_back(8'h00);
    clear_mon();
    for (int i = 0; i < 8; i++) send_pixel((i % 2 == 0) ? 16'hAAAA : 16'hBBBB, 1'b0);
    drain(exp.size());
    tests++;
    if (q.size() != exp.size()) begin errors++; $display("FAIL alt_len got %0d want %0d", q.size(), exp.size()); end
    tests++; bad = 0;
    foreach (exp[i]) if (i < q.size() && q[i] !== exp[i] && !bad) begin
      bad = 1; $display("FAIL alt_byte[%0d] got %h want %h", i, q[i], exp[i]);
    end
    if (bad) errors++;
    tests++; if (done_cnt != 1) begin errors++; $display("FAIL alt_row_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_flush_split();
    logic [7:0] exp[$];
    bit bad;
    exp = '{8'h04, 8'h11, 8'h11, 8'h03, 8'h11, 8'h11, 8'h01, 8'h22, 8'h22, 8'h00};
    clear_mon();
    for (int i = 0; i < 7; i++) send_pixel(16'h1111, 1'b0);
    send_pixel(16'h2222, 1'b0);
    tests++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready_low got %b want 0", o_in_ready); end
    drain(exp.size());
    tests++;
    if (q.size() != exp.size()) begin errors++; $display("FAIL flush_len got %0d want %0d", q.size(), exp.size()); end
    tests++; bad = 0;
    foreach (exp[i]) if (i < q.size() && q[i] !== exp[i] && !bad) begin
      bad = 1; $display("FAIL flush_byte[%0d] got %h want %h", i, q[i], exp[i]);
    end
    if (bad) errors++;
    tests++; if (ready_viol != 0) begin errors++; $display("FAIL flush_in_ready_busy got %0d want 0", ready_viol); end
    tests++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready_after got %b want 1", o_in_ready); end
    tests++; if (done_cnt != 1) begin errors++; $display("FAIL flush_row_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_raw();
    logic [7:0] exp[$];
    bit bad;
    for (int i = 0; i < 8; i++) begin
      exp.push_back(8'h00);
      exp.push_back(8'(i));
    end
    clear_mon();
    for (int i = 0; i < 8; i++) send_pixel(16'(i), (i == 0) ? 1'b1 : 1'b0);
    drain(exp.size());
    tests++;
    if (q.size() != exp.size()) begin errors++; $display("FAIL raw_len got %0d want %0d", q.size(), exp.size()); end
    tests++; bad = 0;
    foreach (exp[i]) if (i < q.size() && q[i] !== exp[i] && !bad) begin
      bad = 1; $display("FAIL raw_byte[%0d] got %h want %h", i, q[i], exp[i]);
    end
    if (bad) errors++;
    tests++; if (done_cnt != 1) begin errors++; $display("FAIL raw_row_done_cnt got %0d want 1", done_cnt); end
    tests++; if (done_idx != 16) begin errors++; $display("FAIL raw_row_done_pos got %0d want 16", done_idx); end
  endtask

  task automatic test_stall();
    rand_mode = 1;
    test_uniform_row("stall");
    rand_mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_row_reset();
    send_pixel(16'h1111, 1'b0);
    send_pixel(16'h2222, 1'b0);
    send_pixel(16'h3333, 1'b0);
    RST = 1'b0;
    #1;
    tests++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_o_valid got %b want 0", o_valid); end
    tests++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", o_in_ready); end
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    test_uniform_row("postreset");
  endtask

  initial begin
    out_ready = 1'b1;
    test_reset();
    test_uniform_row("uniform");
    test_alternating();
    test_flush_split();
    test_raw();
    test_stall();
    test_mid_row_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
